// File: rtl/twos_comp_arbiter.sv
// Round-robin arbiter sharing one two's-complement negator between two requesters,
// with a single registered valid/ready result port tagged by requester id.
module twos_comp_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] z,
    output logic             z_id,
    output logic             z_ovf,
    output logic             z_valid,
    input  logic             z_ready,
    output logic             dbg_state
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Handshake: a result transfers on any edge where z_valid && z_ready; a requester's
    // operand transfers on any edge where its gnt is high. z_ready with z_valid low is ignored.
    logic [0:0]       r_state;
    logic             r_last;
    logic [WIDTH-1:0] r_z;
    logic             r_z_id;
    logic             r_z_ovf;

    logic             w_cap_ok;
    logic             w_sel1;
    logic             w_gnt_any;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_neg;

    // A held result leaving this cycle frees the register for a new capture.
    assign w_cap_ok  = (r_state == IDLE) || z_ready;
    assign w_sel1    = (req0 && req1) ? ~r_last : req1;
    assign w_gnt_any = w_cap_ok && (req0 || req1) && !rst;

    assign gnt0 = w_gnt_any && !w_sel1;
    assign gnt1 = w_gnt_any && w_sel1;

    assign w_a_sel = w_sel1 ? a1 : a0;
    assign w_neg   = ~w_a_sel + {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_z     <= '0;
            r_z_id  <= 1'b0;
            r_z_ovf <= 1'b0;
        end else if (w_gnt_any) begin
            r_state <= FULL;
            r_last  <= w_sel1;
            r_z     <= w_neg;
            r_z_id  <= w_sel1;
            r_z_ovf <= (w_a_sel == MOST_NEG);
        end else if ((r_state == FULL) && z_ready) begin
            r_state <= IDLE;
        end
    end

    assign z         = r_z;
    assign z_id      = r_z_id;
    assign z_ovf     = r_z_ovf;
    assign z_valid   = (r_state == FULL);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_twos_comp_arbiter.sv
// Directed bench for twos_comp_arbiter: scoreboard queue of expected {id, ovf, z}
// results, plus a WIDTH=4 instance for the parameter boundary.
module tb_twos_comp_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, z_ready = 1'b0;
    logic [7:0] a0 = '0, a1 = '0;
    logic       gnt0, gnt1, z_id, z_ovf, z_valid, dbg_state;
    logic [7:0] z;

    logic       req0_4 = 1'b0, req1_4 = 1'b0, z_ready_4 = 1'b0;
    logic [3:0] a0_4 = '0, a1_4 = '0;
    logic       gnt0_4, gnt1_4, z_id_4, z_ovf_4, z_valid_4, dbg_state_4;
    logic [3:0] z_4;

    int         n_checks = 0;
    int         n_errors = 0;
    logic       m_last = 1'b1;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    twos_comp_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .a0(a0), .req1(req1), .a1(a1),
        .gnt0(gnt0), .gnt1(gnt1), .z(z), .z_id(z_id), .z_ovf(z_ovf),
        .z_valid(z_valid), .z_ready(z_ready), .dbg_state(dbg_state)
    );

    twos_comp_arbiter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .req0(req0_4), .a0(a0_4), .req1(req1_4), .a1(a1_4),
        .gnt0(gnt0_4), .gnt1(gnt1_4), .z(z_4), .z_id(z_id_4), .z_ovf(z_ovf_4),
        .z_valid(z_valid_4), .z_ready(z_ready_4), .dbg_state(dbg_state_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result for a WIDTH=8 operand granted to requester id.
    task automatic push_exp(input logic id, input logic [7:0] a);
        int         neg;
        logic [7:0] zz;
        neg = (256 - int'(a)) % 256;
        zz  = neg[7:0];
        exp_q.push_back({id, (a == 8'h80), zz});
    endtask

    // Expected grant given current requests, with model pointer update.
    task automatic chk_grant(input string tag);
        logic e0, e1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (req0 && req1) begin
            e0 = m_last;
            e1 = !m_last;
        end else begin
            e0 = req0;
            e1 = req1;
        end
        chk({tag, "_gnt0"}, gnt0, e0);
        chk({tag, "_gnt1"}, gnt1, e1);
        if (e0) begin
            m_last = 1'b0;
            push_exp(1'b0, a0);
        end else if (e1) begin
            m_last = 1'b1;
            push_exp(1'b1, a1);
        end
    endtask

    task automatic chk_head(input string tag, input logic do_pop);
        logic [9:0] e;
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (do_pop) void'(exp_q.pop_front());
            chk({tag, "_valid"}, z_valid, 1'b1);
            chk({tag, "_z"},     z,       e[7:0]);
            chk({tag, "_ovf"},   z_ovf,   e[8]);
            chk({tag, "_id"},    z_id,    e[9]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_z", z, 8'h00);
        chk("rst_valid", z_valid, 1'b0);
        chk("rst_id", z_id, 1'b0);
        chk("rst_ovf", z_ovf, 1'b0);
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        rst = 1'b0;
        m_last = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] bvals[4];
        bvals = '{8'h00, 8'h80, 8'h7F, 8'hFF};

        // Reset with a request pending: no grant may leak out.
        req0 = 1'b1;
        a0   = 8'h55;
        #2;
        do_reset();
        req0 = 1'b0;
        tick();

        // Single request.
        req0 = 1'b1; a0 = 8'hBB; z_ready = 1'b1;
        #1 chk_grant("single");
        tick();
        req0 = 1'b0;
        chk_head("single", 1'b1);
        #1 chk_grant("single_idle");
        tick();
        chk("single_drop", z_valid, 1'b0);

        // Contention after reset alternates 0,1,0,1.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; a0 = 8'h01; a1 = 8'h02; z_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk_grant("cont");
            chk("cont_order", gnt1, i % 2);
            tick();
            chk_head("cont", 1'b1);
        end
        req0 = 1'b0; req1 = 1'b0;
        #1 chk_grant("cont_end");
        tick();
        chk("cont_drop", z_valid, 1'b0);

        // Backpressure: result held, req1 stalls until z_ready returns.
        req0 = 1'b1; a0 = 8'hBB; z_ready = 1'b0;
        #1 chk_grant("bp_first");
        tick();
        req0 = 1'b0; req1 = 1'b1; a1 = 8'h10;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_stall_gnt1", gnt1, 1'b0);
            chk("bp_stall_gnt0", gnt0, 1'b0);
            chk_head("bp_hold", 1'b0);
            tick();
        end
        z_ready = 1'b1;
        #1 chk_head("bp_release", 1'b1);
        chk_grant("bp_resume");
        tick();
        req1 = 1'b0;
        chk_head("bp_next", 1'b1);
        tick();
        chk("bp_drop", z_valid, 1'b0);

        // Arithmetic boundaries, back to back.
        req0 = 1'b1; z_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a0 = bvals[i];
            #1 chk_grant("bound");
            tick();
            chk_head("bound", 1'b1);
        end
        req0 = 1'b0;
        tick();

        // Asynchronous reset while a result is held.
        req0 = 1'b1; a0 = 8'hBB; z_ready = 1'b0;
        #1 chk_grant("ar_load");
        tick();
        req0 = 1'b0;
        chk_head("ar_held", 1'b1);
        req1 = 1'b1; a1 = 8'h33;
        #1 do_reset();
        req0 = 1'b1; a0 = 8'h01; a1 = 8'h02; z_ready = 1'b1;
        #1 chk("ar_contest_gnt0", gnt0, 1'b1);
        chk_grant("ar_contest");
        tick();
        chk_head("ar_contest", 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("ar_empty", exp_q.size(), 0);

        // WIDTH=4 instance.
        req0_4 = 1'b1; a0_4 = 4'b1000; z_ready_4 = 1'b1;
        #1 chk("w4_gnt0", gnt0_4, 1'b1);
        tick();
        chk("w4_min_z", z_4, 4'b1000);
        chk("w4_min_ovf", z_ovf_4, 1'b1);
        chk("w4_min_valid", z_valid_4, 1'b1);
        a0_4 = 4'b0011;
        tick();
        chk("w4_3_z", z_4, 4'b1101);
        chk("w4_3_ovf", z_ovf_4, 1'b0);
        req0_4 = 1'b0;
        tick();
        chk("w4_drop", z_valid_4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
